// File: rtl/dsp_io_pkg.sv
// Shared types and sizing for the DSP core I/O path (TDM bridge and memory interface users).
package dsp_io_pkg;
    localparam int IO_WIDTH             = 24;
    localparam int SLOT_WIDTH           = 32;
    localparam int PHYSICAL_IO_PER_CORE = 8;
    localparam int FRAME_BITS           = SLOT_WIDTH * PHYSICAL_IO_PER_CORE;
    localparam int CNT_W                = $clog2(FRAME_BITS);
    localparam int SLOT_IDX_W           = $clog2(PHYSICAL_IO_PER_CORE);
    localparam int POS_W                = $clog2(SLOT_WIDTH);
    localparam int BIT_IDX_W            = $clog2(IO_WIDTH);

    typedef logic [IO_WIDTH-1:0] io_sample_t;
    typedef io_sample_t [PHYSICAL_IO_PER_CORE-1:0] io_vec_t;
    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} tdm_state_t;

    // MSB-first bit of a sample at slot position pos; pad positions carry 0.
    function automatic logic slot_bit(io_sample_t s, int pos);
        if (pos < IO_WIDTH) return s[BIT_IDX_W'(IO_WIDTH - 1 - pos)];
        return 1'b0;
    endfunction
endpackage

// File: rtl/tdm_io_bridge_if.sv
// TDM pins plus the parallel core-side sample arrays of one DSP core.
interface tdm_io_bridge_if;
    logic                 tdm_bclk;
    logic                 tdm_fsync;
    logic                 tdm_din;
    logic                 tdm_dout;
    dsp_io_pkg::io_vec_t  core_outputs;
    dsp_io_pkg::io_vec_t  core_inputs;
    logic                 frame_tick;
    logic                 sync_err;

    modport master (
        output tdm_bclk, tdm_fsync, tdm_din, core_outputs,
        input  tdm_dout, core_inputs, frame_tick, sync_err
    );
    modport slave (
        input  tdm_bclk, tdm_fsync, tdm_din, core_outputs,
        output tdm_dout, core_inputs, frame_tick, sync_err
    );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an async level, with rise/fall strobes on the synchronised value.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/tdm_io_bridge.sv
// TDM ADC deserialiser / DAC serialiser for one DSP core; bclk and fsync are oversampled on clk.
module tdm_io_bridge
    import dsp_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    tdm_io_bridge_if.slave  io
);
    localparam logic [0:0] S_HUNT = HUNT;
    localparam logic [0:0] S_RUN  = RUN;

    // lane 0: bclk, lane 1: fsync, lane 2: din
    logic [2:0] raw, lvl, rise, fall;
    assign raw = {io.tdm_din, io.tdm_fsync, io.tdm_bclk};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (raw[i]),
            .level (lvl[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    logic bclk_rise, bclk_fall, fs_lvl, din_lvl, unused_edges;
    assign bclk_rise    = rise[0];
    assign bclk_fall    = fall[0];
    assign fs_lvl       = lvl[1];
    assign din_lvl      = lvl[2];
    assign unused_edges = ^{lvl[0], rise[2:1], fall[2:1]};

    logic [0:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    io_vec_t               staging, snap, inputs_q;
    logic [1:0]            vld_pipe;
    logic                  dout_q, err_q;
    logic [SLOT_IDX_W-1:0] slot;
    logic [POS_W-1:0]      pos;
    logic                  last, in_io, tx_bit, rise_run, accept;

    assign slot     = SLOT_IDX_W'(bit_cnt / CNT_W'(SLOT_WIDTH));
    assign pos      = POS_W'(bit_cnt % CNT_W'(SLOT_WIDTH));
    assign last     = (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign in_io    = (int'(pos) < IO_WIDTH);
    assign tx_bit   = slot_bit(snap[slot], int'(pos));
    assign rise_run = (state == S_RUN) && bclk_rise;
    assign accept   = rise_run && fs_lvl && last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_HUNT;
            bit_cnt  <= '0;
            staging  <= '0;
            snap     <= '0;
            inputs_q <= '0;
            vld_pipe <= '0;
            dout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            err_q    <= 1'b0;
            if (state == S_HUNT) begin
                dout_q <= 1'b0;
                if (bclk_rise && fs_lvl) begin
                    state   <= S_RUN;
                    bit_cnt <= '0;
                    snap    <= io.core_outputs;
                end
            end else if (bclk_rise) begin
                if (fs_lvl) begin
                    // Frame boundary: good or misplaced, realign and resnapshot either way.
                    bit_cnt <= '0;
                    snap    <= io.core_outputs;
                    if (last) inputs_q <= staging;
                    else      err_q    <= 1'b1;
                end else if (last) begin
                    err_q  <= 1'b1;
                    state  <= S_HUNT;
                    dout_q <= 1'b0;
                end else begin
                    if (in_io) staging[slot] <= {staging[slot][IO_WIDTH-2:0], din_lvl};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bclk_fall) begin
                dout_q <= tx_bit;
            end
        end
    end

    assign io.core_inputs = inputs_q;
    assign io.tdm_dout    = dout_q;
    assign io.frame_tick  = vld_pipe[1];
    assign io.sync_err    = err_q;
endmodule

// File: tb/tb_tdm_io_bridge.sv
// Directed frames driven at bclk = clk/8; expected core_inputs pushed per frame, checked on frame_tick.
module tb_tdm_io_bridge;
    import dsp_io_pkg::*;
    localparam int N = PHYSICAL_IO_PER_CORE;
    localparam int F = FRAME_BITS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic loopback = 1'b0;
    logic din_drv = 1'b0;
    always #5 clk = ~clk;

    tdm_io_bridge_if bus();
    assign bus.tdm_din = loopback ? bus.tdm_dout : din_drv;

    tdm_io_bridge #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
    );

    int n_checks = 0, n_pass = 0;
    int err_seen = 0, exp_err = 0, ticks_seen = 0, n_pushed = 0;
    io_vec_t exp_q[$];
    io_vec_t va, vb, vc, vd, ve, vg, vh, vp, vq, vr;

    task automatic check(input string name, input logic [IO_WIDTH*N-1:0] act, input logic [IO_WIDTH*N-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sync_err) err_seen++;
            if (bus.frame_tick) begin
                ticks_seen++;
                if (exp_q.size() == 0) check("tick_unexpected", bus.frame_tick, 1'b0);
                else begin
                    io_vec_t e;
                    e = exp_q.pop_front();
                    check("core_inputs", bus.core_inputs, e);
                end
            end
        end
    end

    function automatic logic bit_of(io_vec_t v, int b);
        int s, p;
        s = b / SLOT_WIDTH;
        p = b % SLOT_WIDTH;
        if (p < IO_WIDTH) return v[s][IO_WIDTH-1-p];
        return p[0];  // nonzero pad junk must be ignored by the receiver
    endfunction

    task automatic send_bit(input logic d, input logic fs, input int mode, input int b);
        bus.tdm_bclk  = 1'b0;
        din_drv       = d;
        bus.tdm_fsync = fs;
        repeat (4) @(posedge clk);
        #1 bus.tdm_bclk = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (mode == 1 && (b % SLOT_WIDTH) >= IO_WIDTH) check("pad_bit_zero", bus.tdm_dout, 1'b0);
        if (mode == 2 && (b % SLOT_WIDTH) == 0) check("hunt_dout_zero", bus.tdm_dout, 1'b0);
    endtask

    task automatic send_frame(input io_vec_t v, input int nbits, input int fs_pos, input int mode);
        for (int b = 0; b < nbits; b++) send_bit(bit_of(v, b), b == fs_pos, mode, b);
    endtask

    task automatic expect_frame(input io_vec_t v);
        exp_q.push_back(v);
        n_pushed++;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            va[k] = 24'hA00000 + 24'(k);
            vb[k] = 24'h3C5A00 + 24'(k * 17);
            vc[k] = 24'hFFFF00 - 24'(k);
            vd[k] = 24'h0F1E2D ^ 24'(k << 8);
            ve[k] = 24'h777777;
            vg[k] = 24'h800001 + 24'(k << 4);
            vh[k] = 24'h010203 * 24'(k + 1);
            vp[k] = 24'h5A5A00 | 24'(k);
            vq[k] = 24'hC3A500 | 24'(k << 2);
            vr[k] = 24'hFFFFFF;
        end
        bus.tdm_bclk     = 1'b1;
        bus.tdm_fsync    = 1'b0;
        bus.core_outputs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_core_inputs", bus.core_inputs, '0);
        check("reset_dout", bus.tdm_dout, 1'b0);
        check("reset_frame_tick", bus.frame_tick, 1'b0);
        check("reset_sync_err", bus.sync_err, 1'b0);
        reset = 1'b0;

        // Clean frames: first fsync only enters RUN
        send_frame(va, F, F - 1, 0);
        expect_frame(va);
        send_frame(va, F, F - 1, 0);
        expect_frame(vb);
        send_frame(vb, F, F - 1, 0);

        // Early fsync at bit 100
        exp_err++;
        send_frame(vc, 101, 100, 0);
        check("hold_after_early_fsync", bus.core_inputs, vb);
        check("sync_err_early", err_seen, exp_err);
        expect_frame(vd);
        send_frame(vd, F, F - 1, 0);

        // Dropped fsync -> HUNT, re-lock, tick one frame later
        bus.core_outputs = vr;
        exp_err++;
        send_frame(ve, F, -1, 0);
        check("sync_err_dropped", err_seen, exp_err);
        send_frame(ve, F, F - 1, 2);
        expect_frame(vg);
        send_frame(vg, F, F - 1, 0);

        // Reset mid-slot 3 while transmitting all-ones
        send_frame(vc, 3 * SLOT_WIDTH + 14, -1, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_core_inputs", bus.core_inputs, '0);
        check("midreset_dout", bus.tdm_dout, 1'b0);
        check("midreset_frame_tick", bus.frame_tick, 1'b0);
        check("midreset_sync_err", bus.sync_err, 1'b0);
        reset = 1'b0;
        send_frame(vc, F, F - 1, 0);
        bus.core_outputs = vp;
        expect_frame(vh);
        send_frame(vh, F, F - 1, 0);

        // Loopback; core_outputs changes 1 clk after each accepting fsync
        bus.core_outputs = vq;
        loopback = 1'b1;
        expect_frame(vp);
        send_frame(va, F, F - 1, 1);
        bus.core_outputs = vr;
        expect_frame(vq);
        send_frame(va, F, F - 1, 1);

        repeat (20) @(posedge clk);
        #1;
        check("ticks_total", ticks_seen, n_pushed);
        check("sync_err_total", err_seen, exp_err);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
